// File: rtl/seg_scan_encoder.sv
// Key-press priority encoder with a DIGITS-deep hex history, scanned onto a
// common-anode 7-segment display. Define SEG_SCAN_DP_EN to add the dp_n output.
module seg_scan_encoder #(
    parameter int N_IN   = 8,
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    localparam int IW    = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in,
    input  logic              clr,
    output logic [IW-1:0]     code,
    output logic              code_valid,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n
`ifdef SEG_SCAN_DP_EN
    ,
    output logic              dp_n
`endif
);

    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DIV);

    logic [N_IN-1:0]            sync1;
    logic [N_IN-1:0]            sync2;
    logic [N_IN-1:0]            prev;
    logic                       press;
    logic [IW-1:0]              press_idx;

    logic [DIGITS-1:0]          slot_valid;
    logic [DIGITS-1:0][IW-1:0]  slot_val;

    logic [CW-1:0]              pre_cnt;
    logic [SW-1:0]              scan_idx;

    logic                       cur_valid;
    logic [IW-1:0]              cur_val;
    logic [6:0]                 seg_next;
    logic [DIGITS-1:0]          an_next;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0:    f = 7'b0000001;
            4'h1:    f = 7'b1001111;
            4'h2:    f = 7'b0010010;
            4'h3:    f = 7'b0000110;
            4'h4:    f = 7'b1001100;
            4'h5:    f = 7'b0100100;
            4'h6:    f = 7'b0100000;
            4'h7:    f = 7'b0001111;
            4'h8:    f = 7'b0000000;
            4'h9:    f = 7'b0000100;
            4'hA:    f = 7'b0001000;
            4'hB:    f = 7'b1100000;
            4'hC:    f = 7'b0110001;
            4'hD:    f = 7'b1000010;
            4'hE:    f = 7'b0110000;
            default: f = 7'b0111000;
        endcase
        return f;
    endfunction

    // prev holds the previous synchronised sample so only a 0 -> nonzero step counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = (sync2 != '0) && (prev == '0);

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2[i]) press_idx = IW'(i);
        end
    end

    // code_valid is a one-cycle qualifier for code with no back-pressure:
    // a consumer must take code in the cycle code_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            code_valid <= press && !clr;
            if (press && !clr) code <= press_idx;
        end
    end

    // Slot 0 sits in the low bits, so a left shift ages every entry by one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            slot_val   <= '0;
        end else if (clr) begin
            slot_valid <= '0;
        end else if (press) begin
            slot_valid <= (slot_valid << 1) | DIGITS'(1);
            slot_val   <= (slot_val << IW) | (DIGITS * IW)'(press_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            scan_idx <= '0;
        end else if (pre_cnt == CW'(DIV - 1)) begin
            pre_cnt  <= '0;
            scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
        end else begin
            pre_cnt  <= pre_cnt + CW'(1);
        end
    end

    always_comb begin
        cur_valid = 1'b0;
        cur_val   = '0;
        an_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == SW'(i)) begin
                cur_valid = slot_valid[i];
                cur_val   = slot_val[i];
            end
            an_next[i] = (scan_idx != SW'(i));
        end
        seg_next = cur_valid ? hex_font(4'(cur_val)) : 7'h7F;
    end

    // Anode and segments are registered together so digits never ghost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= 7'h7F;
            an_n  <= '1;
        end else begin
            seg_n <= seg_next;
            an_n  <= an_next;
        end
    end

`ifdef SEG_SCAN_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_n <= 1'b1;
        end else begin
            dp_n <= !((scan_idx == '0) && slot_valid[0]);
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Bench for seg_scan_encoder: table vectors, hand sequences and random presses
// checked against a queue-based history model; a second instance covers N_IN=16, DIGITS=1.
module tb_seg_scan_encoder;

  localparam int N_IN   = 8;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  in = '0;
  logic        clr = 1'b0;
  logic [2:0]  code;
  logic        code_valid;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;

  logic [15:0] b_in = '0;
  logic        b_clr = 1'b0;
  logic [3:0]  b_code;
  logic        b_code_valid;
  logic [6:0]  b_seg_n;
  logic [0:0]  b_an_n;
  logic        b_dp_n;

  seg_scan_encoder #(.N_IN(N_IN), .DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .in(in), .clr(clr), .code(code),
    .code_valid(code_valid), .seg_n(seg_n), .an_n(an_n)
`ifdef SEG_SCAN_DP_EN
    , .dp_n(dp_n)
`endif
  );

  seg_scan_encoder #(.N_IN(16), .DIGITS(1), .DIV(DIV)) dut_b (
    .clk(clk), .rst(rst), .in(b_in), .clr(b_clr), .code(b_code),
    .code_valid(b_code_valid), .seg_n(b_seg_n), .an_n(b_an_n)
`ifdef SEG_SCAN_DP_EN
    , .dp_n(b_dp_n)
`endif
  );

`ifndef SEG_SCAN_DP_EN
  assign dp_n   = 1'b1;
  assign b_dp_n = 1'b1;
`endif

  // scoreboard and reference model state
  int n_pass   = 0;
  int n_checks = 0;
  logic [2:0] exp_q[$];
  int hist[$];          // newest press first, at most DIGITS entries
  int s1, s2, s3;       // values of in seen at the last three edges
  int m_code;
  int cyc;              // edges since reset release

  typedef struct {
    logic [7:0] in;
    int         code;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    s1 = 0; s2 = 0; s3 = 0;
    hist.delete();
    exp_q.delete();
    m_code = 0;
    cyc = 0;
  endtask

  // One clock edge: predict from the pre-edge model, advance, compare at +1.
  task automatic tick();
    bit         pr;
    int         idx;
    int         scan;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic       e_cv;
    pr   = (s2 != 0) && (s3 == 0);
    idx  = pr ? $clog2(s2 + 1) - 1 : 0;
    cyc++;
    scan  = ((cyc - 1) / DIV) % DIGITS;
    e_seg = (scan < hist.size()) ? FONT[hist[scan]] : 7'h7F;
    e_an  = ~(4'b0001 << scan);
    e_dp  = !(scan == 0 && hist.size() > 0);
    e_cv  = pr && !clr;
    if (e_cv) begin
      m_code = idx;
      exp_q.push_back(3'(idx));
    end
    s3 = s2; s2 = s1; s1 = int'(in);
    if (clr) hist.delete();
    else if (pr) begin
      hist.push_front(idx);
      if (hist.size() > DIGITS) void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
    check("code_valid", code_valid, e_cv);
    check("code", code, m_code);
    check("seg_n", seg_n, e_seg);
    check("an_n", an_n, e_an);
`ifdef SEG_SCAN_DP_EN
    check("dp_n", dp_n, e_dp);
`endif
    if (code_valid) begin
      if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
      else check("sb_code", code, exp_q.pop_front());
    end
  endtask

  task automatic do_reset(input int cycles, input logic [7:0] hold_in);
    rst = 1'b1; in = hold_in; clr = 1'b0; b_in = '0; b_clr = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_seg", seg_n, 7'h7F);
      check("rst_an", an_n, 4'hF);
      check("rst_cv", code_valid, 0);
      check("rst_code", code, 0);
      check("rst_b_an", b_an_n, 1);
    end
    rst = 1'b0;
    in  = '0;
    model_reset();
  endtask

  task automatic wait_digit(input int d);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    for (int k = 0; k < 40 && an_n != want; k++) tick();
    check("wait_an", an_n, want);
  endtask

  task automatic press_release(input logic [7:0] v);
    in = v;
    repeat (4) tick();
    in = '0;
    repeat (2) tick();
  endtask

  initial begin
    int pulses;
    int ph;
    logic [3:0] a;

    vecs[0] = '{8'h01, 0};
    vecs[1] = '{8'h84, 7};
    vecs[2] = '{8'h24, 5};
    vecs[3] = '{8'h80, 7};
    vecs[4] = '{8'hFF, 7};
    vecs[5] = '{8'h02, 1};
    vecs[6] = '{8'h10, 4};
    vecs[7] = '{8'h03, 1};

    // reset with input active, then a blank scan walk
    do_reset(5, 8'h10);
    for (int i = 0; i < 20; i++) begin
      tick();
      ph = (i / DIV) % DIGITS;
      a  = ~(4'b0001 << ph);
      check("walk_an", an_n, a);
      check("walk_seg", seg_n, 7'h7F);
    end

    // single press latency
    in = 8'h01;
    tick(); check("lat1_cv", code_valid, 0);
    tick(); check("lat2_cv", code_valid, 0);
    tick(); check("lat3_cv", code_valid, 1); check("lat3_code", code, 0);
    in = '0;
    tick(); check("lat4_cv", code_valid, 0);
    wait_digit(0);
    check("single_seg", seg_n, FONT[0]);

    // table of priority vectors
    foreach (vecs[v]) begin
      in = vecs[v].in;
      repeat (3) tick();
      check("tbl_cv", code_valid, 1);
      check("tbl_code", code, vecs[v].code);
      repeat (2) tick();
      in = '0;
      repeat (2) tick();
      wait_digit(0);
      check("tbl_seg", seg_n, FONT[vecs[v].code]);
    end

    // held input gives a single press
    pulses = 0;
    in = 8'b1000_0100;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (code_valid) pulses++;
    end
    check("hold_pulses", pulses, 1);
    wait_digit(0);
    check("hold_seg", seg_n, FONT[7]);
    in = '0;
    repeat (2) tick();

    // history shift: 1..5, oldest drops off
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 1; k <= 5; k++) press_release(8'(1 << k));
    for (int i = 0; i < 16; i++) begin
      tick();
      for (int d = 0; d < DIGITS; d++) begin
        a = ~(4'b0001 << d);
        if (an_n == a) check("hist_seg", seg_n, FONT[5 - d]);
      end
    end

    // clear colliding with a press
    in = 8'h08;
    tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("coll_cv", code_valid, 0);
    check("coll_code", code, 5);
    in = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("coll_blank", seg_n, 7'h7F);
    end
    press_release(8'h40);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an_n == 4'hE) check("after_d0", seg_n, FONT[6]);
      else check("after_blank", seg_n, 7'h7F);
    end

    // randomized presses, clears and direct switches between nonzero values
    for (int n = 0; n < 40; n++) begin
      in = 8'($urandom_range(1, 255));
      repeat ($urandom_range(1, 6)) begin
        clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      clr = 1'b0;
      if ($urandom_range(0, 3) != 0) in = '0;
      repeat ($urandom_range(0, 4)) tick();
    end
    in = '0;

    // asynchronous reset in the middle of a scan
    #3;
    rst = 1'b1;
    #1;
    check("async_an", an_n, 4'hF);
    check("async_seg", seg_n, 7'h7F);
    check("async_code", code, 0);
    check("async_cv", code_valid, 0);
    do_reset(2, 8'h00);
    repeat (8) tick();

    // wide input, single digit instance
    b_in = 16'h8000;
    tick(); check("b_lat1", b_code_valid, 0);
    tick(); check("b_lat2", b_code_valid, 0);
    tick(); check("b_cv", b_code_valid, 1); check("b_code", b_code, 4'hF);
    b_in = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b_seg", b_seg_n, FONT[15]);
      check("b_an", b_an_n, 0);
`ifdef SEG_SCAN_DP_EN
      check("b_dp", b_dp_n, 0);
`endif
    end
    b_clr = 1'b1; tick(); b_clr = 1'b0;
    check("b_clr_cv", b_code_valid, 0);
    tick();
    check("b_clr_seg", b_seg_n, 7'h7F);
    check("b_clr_an", b_an_n, 0);
    check("b_clr_code", b_code, 4'hF);
`ifdef SEG_SCAN_DP_EN
    check("b_clr_dp", b_dp_n, 1);
`endif

    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
